// File: rtl/fb_pkg.sv
// Shared constants and FSM state types for the frame buffer controller.
package fb_pkg;

    localparam int unsigned FB_WIDTH  = 640;
    localparam int unsigned FB_HEIGHT = 480;
    localparam int unsigned FB_DATA_W = 3;
    localparam int unsigned X_W       = 10;
    localparam int unsigned Y_W       = 9;

    typedef enum logic {W_IDLE, W_CLEAR} w_state_e;
    typedef enum logic {R_IDLE, R_SCAN}  r_state_e;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y address counter with synchronous clear, enable, wrap and last flag.
module raster_counter
    import fb_pkg::*;
#(
    parameter int unsigned WIDTH  = FB_WIDTH,
    parameter int unsigned HEIGHT = FB_HEIGHT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           en,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           x_end, y_end;

    assign x_end = (x_q == X_W'(WIDTH - 1));
    assign y_end = (y_q == Y_W'(HEIGHT - 1));
    assign last  = x_end && y_end;
    assign x     = x_q;
    assign y     = y_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (en) begin
            if (x_end) begin
                x_d = '0;
                y_d = y_end ? '0 : y_q + Y_W'(1);
            end else begin
                x_d = x_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Arbitrates the frame RAM write port between bulk clear and pixel writes,
// and issues raster-order read scans with a one-cycle data pipeline.
module frame_buffer_ctrl
    import fb_pkg::*;
#(
    parameter int unsigned WIDTH  = FB_WIDTH,
    parameter int unsigned HEIGHT = FB_HEIGHT,
    parameter int unsigned DATA_W = FB_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    input  logic [DATA_W-1:0] clear_color,
    output logic              clear_busy,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [X_W-1:0]    pix_x,
    input  logic [Y_W-1:0]    pix_y,
    input  logic [DATA_W-1:0] pix_color,
    input  logic              scan_start,
    output logic              out_valid,
    output logic [X_W-1:0]    out_x,
    output logic [Y_W-1:0]    out_y,
    output logic [DATA_W-1:0] out_data,
    output logic              scan_done,
    output logic [X_W-1:0]    fb_write_frame_width,
    output logic [Y_W-1:0]    fb_write_frame_height,
    output logic              fb_write_enable,
    output logic [DATA_W-1:0] fb_write_data,
    output logic [X_W-1:0]    fb_read_frame_width,
    output logic [Y_W-1:0]    fb_read_frame_height,
    input  logic [DATA_W-1:0] fb_read_data
);

    w_state_e          w_state_q, w_state_d;
    r_state_e          r_state_q, r_state_d;
    logic [DATA_W-1:0] clr_color_q, clr_color_d;
    logic              pix_we_q, pix_we_d;
    logic [X_W-1:0]    pix_x_q, pix_x_d;
    logic [Y_W-1:0]    pix_y_q, pix_y_d;
    logic [DATA_W-1:0] pix_data_q, pix_data_d;
    logic              clr_start, clr_en, clr_last;
    logic [X_W-1:0]    clr_x;
    logic [Y_W-1:0]    clr_y;
    logic              scan_go, scan_en, scan_last;
    logic [X_W-1:0]    scan_x;
    logic [Y_W-1:0]    scan_y;
    logic              in_range;
    logic              out_valid_q, scan_done_q;
    logic [X_W-1:0]    out_x_q;
    logic [Y_W-1:0]    out_y_q;

    assign in_range = (pix_x < X_W'(WIDTH)) && (pix_y < Y_W'(HEIGHT));

    raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_clear_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_start),
        .en    (clr_en),
        .x     (clr_x),
        .y     (clr_y),
        .last  (clr_last)
    );

    raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_scan_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (scan_go),
        .en    (scan_en),
        .x     (scan_x),
        .y     (scan_y),
        .last  (scan_last)
    );

    // Write FSM; clear_req beats a same-cycle pixel by withholding pix_ready.
    always_comb begin
        w_state_d   = w_state_q;
        clr_color_d = clr_color_q;
        pix_we_d    = 1'b0;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_data_d  = pix_data_q;
        pix_ready   = 1'b0;
        clear_busy  = 1'b0;
        clr_start   = 1'b0;
        clr_en      = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                pix_ready = !clear_req;
                if (clear_req) begin
                    clr_start   = 1'b1;
                    clr_color_d = clear_color;
                    w_state_d   = W_CLEAR;
                end else if (pix_valid) begin
                    pix_we_d   = in_range;
                    pix_x_d    = pix_x;
                    pix_y_d    = pix_y;
                    pix_data_d = pix_color;
                end
            end
            W_CLEAR: begin
                clear_busy = 1'b1;
                clr_en     = 1'b1;
                if (clr_last) begin
                    w_state_d = W_IDLE;
                end
            end
        endcase
    end

    // Read FSM
    assign scan_go = (r_state_q == R_IDLE) && scan_start;
    assign scan_en = (r_state_q == R_SCAN);

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            R_IDLE: if (scan_start) r_state_d = R_SCAN;
            R_SCAN: if (scan_last)  r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            clr_color_q <= '0;
            pix_we_q    <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            scan_done_q <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            clr_color_q <= clr_color_d;
            pix_we_q    <= pix_we_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_data_q  <= pix_data_d;
            out_valid_q <= scan_en;
            out_x_q     <= scan_x;
            out_y_q     <= scan_y;
            scan_done_q <= scan_en && scan_last;
        end
    end

    assign fb_write_enable       = clear_busy | pix_we_q;
    assign fb_write_frame_width  = clear_busy ? clr_x : pix_x_q;
    assign fb_write_frame_height = clear_busy ? clr_y : pix_y_q;
    assign fb_write_data         = clear_busy ? clr_color_q : pix_data_q;

    // Scan counter rests at (0,0) when idle, so the read address is 0 then.
    assign fb_read_frame_width  = scan_x;
    assign fb_read_frame_height = scan_y;

    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_data  = out_valid_q ? fb_read_data : '0;
    assign scan_done = scan_done_q;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed bench for frame_buffer_ctrl on a reduced 8x4 frame with a behavioural frame RAM.
module tb_frame_buffer_ctrl;
    import fb_pkg::*;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int DW = 3;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear_req;
    logic [DW-1:0] clear_color;
    logic          clear_busy;
    logic          pix_valid;
    logic          pix_ready;
    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;
    logic [DW-1:0] pix_color;
    logic          scan_start;
    logic          out_valid;
    logic [X_W-1:0] out_x;
    logic [Y_W-1:0] out_y;
    logic [DW-1:0] out_data;
    logic          scan_done;
    logic [X_W-1:0] fb_write_frame_width;
    logic [Y_W-1:0] fb_write_frame_height;
    logic          fb_write_enable;
    logic [DW-1:0] fb_write_data;
    logic [X_W-1:0] fb_read_frame_width;
    logic [Y_W-1:0] fb_read_frame_height;
    logic [DW-1:0] fb_read_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] ram [N];
    logic [DW-1:0] exp_fb [N];
    logic [DW-1:0] ram_rd;
    int            ram_writes = 0;

    always #5 clk = ~clk;

    frame_buffer_ctrl #(.WIDTH(W), .HEIGHT(H), .DATA_W(DW)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .clear_req             (clear_req),
        .clear_color           (clear_color),
        .clear_busy            (clear_busy),
        .pix_valid             (pix_valid),
        .pix_ready             (pix_ready),
        .pix_x                 (pix_x),
        .pix_y                 (pix_y),
        .pix_color             (pix_color),
        .scan_start            (scan_start),
        .out_valid             (out_valid),
        .out_x                 (out_x),
        .out_y                 (out_y),
        .out_data              (out_data),
        .scan_done             (scan_done),
        .fb_write_frame_width  (fb_write_frame_width),
        .fb_write_frame_height (fb_write_frame_height),
        .fb_write_enable       (fb_write_enable),
        .fb_write_data         (fb_write_data),
        .fb_read_frame_width   (fb_read_frame_width),
        .fb_read_frame_height  (fb_read_frame_height),
        .fb_read_data          (fb_read_data)
    );

    // Frame RAM: write at the edge, registered read one cycle after address.
    always @(posedge clk) begin
        int widx, ridx;
        widx = int'(fb_write_frame_height) * W + int'(fb_write_frame_width);
        ridx = int'(fb_read_frame_height) * W + int'(fb_read_frame_width);
        if (fb_write_enable) begin
            if (widx < N) ram[widx] <= fb_write_data;
            ram_writes <= ram_writes + 1;
        end
        if (ridx < N) ram_rd <= ram[ridx];
    end
    assign fb_read_data = ram_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic run_clear(input string tag, input logic [DW-1:0] color,
                             input bit hold_pix, input bit rereq);
        int busy, bad;
        busy = 0;
        bad  = 0;
        @(posedge clk); #1;
        clear_req   = 1'b1;
        clear_color = color;
        if (hold_pix) begin
            pix_valid = 1'b1; pix_x = 10'd3; pix_y = 9'd2; pix_color = 3'd6;
        end
        @(negedge clk);
        check({tag, ":ready_on_req"}, pix_ready, 0);
        @(posedge clk); #1;
        clear_req   = 1'b0;
        clear_color = ~color;
        for (int i = 1; i <= N + 8; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check({tag, ":first_we"}, fb_write_enable, 1);
                check({tag, ":first_addr"}, {fb_write_frame_height, fb_write_frame_width}, 0);
                check({tag, ":first_data"}, fb_write_data, color);
            end
            if (!clear_busy) break;
            busy++;
            if (pix_ready || !fb_write_enable || fb_write_data !== color) bad++;
            if (rereq && i == 5) clear_req = 1'b1;
            if (i == 6) clear_req = 1'b0;
        end
        check({tag, ":busy_cycles"}, busy, N);
        check({tag, ":bad_cycles"}, bad, 0);
        for (int k = 0; k < N; k++) exp_fb[k] = color;
        if (hold_pix) begin
            check({tag, ":ready_after"}, pix_ready, 1);
            @(posedge clk); #1;
            pix_valid = 1'b0;
            @(negedge clk);
            check({tag, ":held_we"}, fb_write_enable, 1);
            check({tag, ":held_addr"}, {fb_write_frame_height, fb_write_frame_width},
                  {9'd2, 10'd3});
            check({tag, ":held_data"}, fb_write_data, 6);
            exp_fb[2 * W + 3] = 3'd6;
        end
    endtask

    task automatic run_scan(input string tag, input bit restart);
        int nvalid, first_rel, done_rel, ndone, aerr, derr, done_x, done_y;
        nvalid = 0; first_rel = -1; done_rel = -1; ndone = 0;
        aerr = 0; derr = 0; done_x = -1; done_y = -1;
        @(posedge clk); #1;
        scan_start = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
        for (int i = 1; i <= N + 8; i++) begin
            @(negedge clk);
            if (out_valid) begin
                if (first_rel < 0) first_rel = i;
                if (nvalid >= N || int'(out_x) != nvalid % W || int'(out_y) != nvalid / W)
                    aerr++;
                else if (out_data !== exp_fb[nvalid])
                    derr++;
                nvalid++;
            end
            if (scan_done) begin
                ndone++;
                done_rel = i;
                done_x   = int'(out_x);
                done_y   = int'(out_y);
            end
            if (restart && i == 5) scan_start = 1'b1;
            if (i == 6) scan_start = 1'b0;
        end
        check({tag, ":valid_count"}, nvalid, N);
        check({tag, ":first_valid_cycle"}, first_rel, 2);
        check({tag, ":done_cycle"}, done_rel, N + 1);
        check({tag, ":done_count"}, ndone, 1);
        check({tag, ":done_x"}, done_x, W - 1);
        check({tag, ":done_y"}, done_y, H - 1);
        check({tag, ":addr_errors"}, aerr, 0);
        check({tag, ":data_errors"}, derr, 0);
    endtask

    initial begin
        int px [6] = '{0, 7, 0, 7, 8, 0};
        int py [6] = '{0, 0, 3, 3, 0, 4};
        int pc [6] = '{1, 2, 3, 7, 6, 6};
        int we_exp [6] = '{1, 1, 1, 1, 0, 0};
        int we_seen [7];
        int w0;

        rst_n = 1'b0; clear_req = 1'b0; clear_color = '0; pix_valid = 1'b0;
        pix_x = '0; pix_y = '0; pix_color = '0; scan_start = 1'b0;
        #12;
        check("rst:fb_we", fb_write_enable, 0);
        check("rst:fb_waddr", {fb_write_frame_height, fb_write_frame_width}, 0);
        check("rst:fb_wdata", fb_write_data, 0);
        check("rst:fb_raddr", {fb_read_frame_height, fb_read_frame_width}, 0);
        check("rst:clear_busy", clear_busy, 0);
        check("rst:pix_ready", pix_ready, 1);
        check("rst:out_valid", out_valid, 0);
        check("rst:out_xy_data", {out_y, out_x, out_data}, 0);
        check("rst:scan_done", scan_done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Clear to 5 with a held pixel and a re-request mid-clear, then a restarted scan.
        run_clear("clr5", 3'd5, 1'b1, 1'b1);
        run_scan("scan5", 1'b1);

        // Clear to 0, then back-to-back corner pixels and two out-of-range pixels.
        run_clear("clr0", 3'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        w0 = ram_writes;
        for (int i = 0; i < 6; i++) begin
            pix_valid = 1'b1;
            pix_x     = X_W'(px[i]);
            pix_y     = Y_W'(py[i]);
            pix_color = DW'(pc[i]);
            @(negedge clk);
            we_seen[i] = int'(fb_write_enable);
            if (i == 0) check("pix:ready", pix_ready, 1);
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        @(negedge clk);
        we_seen[6] = int'(fb_write_enable);
        for (int i = 0; i < 6; i++) check($sformatf("pix:we_%0d", i), we_seen[i + 1], we_exp[i]);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pix:ram_writes", ram_writes - w0, 4);
        exp_fb[0]                 = 3'd1;
        exp_fb[W - 1]             = 3'd2;
        exp_fb[(H - 1) * W]       = 3'd3;
        exp_fb[(H - 1) * W + W - 1] = 3'd7;
        run_scan("scanpix", 1'b0);

        // Reset in the middle of a clear.
        @(posedge clk); #1;
        clear_req = 1'b1; clear_color = 3'd4;
        @(posedge clk); #1;
        clear_req = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        check("rstmid:busy_before", clear_busy, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid:busy", clear_busy, 0);
        check("rstmid:fb_we", fb_write_enable, 0);
        check("rstmid:fb_waddr", {fb_write_frame_height, fb_write_frame_width}, 0);
        check("rstmid:pix_ready", pix_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid:busy_after", clear_busy, 0);
        check("rstmid:ready_after", pix_ready, 1);
        check("rstmid:we_after", fb_write_enable, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
